dm_access_controller: RTL and testbench
=======================================

# dm_access_controller

Sequencer for the data-memory (DM) stage of the SimpleRISC pipeline. It sits behind the ALU→DM pipeline register and drives the data memory through a req/ack handshake with variable latency. While an access is in flight it stalls the upstream pipeline. On completion it delivers the load result, with its destination register, to writeback and forwarding.

## Interface
Parameters:
- TIMEOUT, default 15: maximum number of REQ cycles without `mem_ack` before the access is aborted (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- isLd_DM  in  1  instruction in the DM stage is a load
- isSt_DM  in  1  instruction in the DM stage is a store
- aluResult_DM  in  32  effective address
- op2_DM  in  32  store data
- rd_DM  in  5  load destination register
- mem_req  out  1  memory request; held until ack or abort
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req`
- mem_addr  out  32  latched address; valid while `mem_req`
- mem_wdata  out  32  latched store data; valid while `mem_req`
- mem_ack  in  1  memory completion; sampled only in REQ
- mem_rdata  in  32  read data; valid in the `mem_ack` cycle
- stall  out  1  freeze PC and all pipe registers up to and including ALU→DM
- ldValid  out  1  one-cycle pulse: load data available
- ldResult  out  32  load data, held until the next load completes
- ldRd  out  5  destination register of `ldResult`
- timeout_err  out  1  sticky; an access was aborted

## Operation
- FSM states are IDLE, REQ and DONE. The state register is 2 bits wide.
- IDLE, access detected:
  - An access is detected when `isLd_DM | isSt_DM` is high.
  - `stall` = 1 combinationally in this cycle.
  - On the edge: latch `aluResult_DM` into `mem_addr` and `op2_DM` into `mem_wdata`.
  - On the edge: set `mem_we` = `isSt_DM`, latch `rd_DM` into the internal rd register, and clear the timeout counter.
  - Next state is REQ.
- IDLE, both flags high: treated as a store and the load is ignored. `mem_we` = 1 and no `ldValid` pulse is produced.
- REQ:
  - `mem_req` = 1 and `stall` = 1. Address, data and `mem_we` stay constant.
  - The counter increments every REQ cycle.
  - If `mem_ack` = 1: for a read, capture `mem_rdata` into `ldResult` and rd into `ldRd`. Next state is DONE.
  - If `mem_ack` = 0 and counter = TIMEOUT−1: set `timeout_err`. Next state is DONE and no load data is captured.
  - Otherwise remain in REQ.
- DONE:
  - `stall` = 0, so the pipeline advances at the end of this cycle.
  - `ldValid` = 1 only for a read that was acked.
  - `isLd_DM`/`isSt_DM` are ignored, because they still reflect the completed instruction.
  - Next state is always IDLE.
- `mem_ack` outside REQ is ignored.
- `timeout_err` clears only on reset.
- Registered outputs are `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `ldValid`, `ldResult`, `ldRd` and `timeout_err`. `stall` is a combinational decode of the state and inputs.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State goes to IDLE, counter to 0.
  - Every registered output goes to 0.
  - `stall` follows IDLE decode: `isLd_DM | isSt_DM` while in IDLE, 0 while `rst_n` is low.
- Reset mid-access: `mem_req` drops at that edge, no `ldValid` is produced, and the aborted access is not retried.
- Access detected at cycle 0, ack arrives k cycles after the first REQ cycle (k ≥ 0):
  - REQ spans cycles 1..1+k.
  - DONE is at cycle 2+k.
  - `stall` is high for cycles 0..1+k, giving 2+k stall cycles.
- Minimum access (ack in the first REQ cycle): 2 stall cycles, `ldValid` at cycle 2.
- Timeout: REQ lasts exactly TIMEOUT cycles. DONE follows with `ldValid` = 0 and `timeout_err` = 1 from DONE onward.
- Back-to-back accesses: the next instruction reaches DM at the cycle after DONE, where the FSM is IDLE. Detection restarts there, so there are no dead cycles beyond DONE.
- Non-memory instructions in IDLE: `stall` = 0 and no state change.

## Test plan
- Reset: hold `rst_n` = 0 with `isLd_DM` = 1 for 2 cycles.
  - All registered outputs are 0 and `stall` = 0.
  - After release, the access starts in the first IDLE cycle.
- Load, ack with k = 0: address 0x100, `rd_DM` = 5, `mem_rdata` = 0xDEADBEEF.
  - `stall` is high for 2 cycles.
  - `mem_req` is high for 1 cycle with `mem_addr` = 0x100 and `mem_we` = 0.
  - At cycle 2: `ldValid` pulses, `ldResult` = 0xDEADBEEF, `ldRd` = 5.
- Store, ack with k = 3: address 0x40, data 0x12345678.
  - `mem_req` is high for 4 cycles with `mem_we` = 1 and address/data stable.
  - `stall` is high for 5 cycles and `ldValid` never pulses.
- Timeout with TIMEOUT = 15, no ack:
  - `mem_req` is high for exactly 15 cycles.
  - `timeout_err` = 1 and stays set.
  - `ldValid` = 0 and `ldResult` is unchanged.
- Load, then store in the next instruction:
  - The second access is detected in the cycle after DONE.
  - A stray `mem_ack` asserted during DONE/IDLE is ignored.
  - The `isLd_DM` = `isSt_DM` = 1 case is issued as a write.
- Reset asserted in the 2nd REQ cycle of a load:
  - `mem_req` = 0 after the reset edge and no `ldValid` pulse occurs.
  - The FSM returns to IDLE.

Source files
------------

// File: rtl/dm_access_controller.sv
// Data-memory stage sequencer: launches a req/ack access for each load/store,
// stalls the pipeline while it is in flight and returns load data to writeback.
module dm_access_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isLd_DM,
  input  logic        isSt_DM,
  input  logic [31:0] aluResult_DM,
  input  logic [31:0] op2_DM,
  input  logic [4:0]  rd_DM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        ldValid,
  output logic [31:0] ldResult,
  output logic [4:0]  ldRd,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_result_q, ld_result_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        timeout_err_q, timeout_err_d;
  logic        access;

  assign access = isLd_DM | isSt_DM;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_d          = rd_q;
    ld_valid_d    = 1'b0;
    ld_result_d   = ld_result_q;
    ld_rd_d       = ld_rd_q;
    timeout_err_d = timeout_err_q;
    stall         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          // A load+store combination is issued as a store; the load part is dropped.
          stall       = 1'b1;
          state_d     = S_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = isSt_DM;
          mem_addr_d  = aluResult_DM;
          mem_wdata_d = op2_DM;
          rd_d        = rd_DM;
          cnt_d       = 8'd0;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            ld_valid_d  = 1'b1;
            ld_result_d = mem_rdata;
            ld_rd_d     = rd_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_DONE;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The pipeline must not see a stall request while the sequencer is held in reset.
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      rd_q          <= 5'd0;
      ld_valid_q    <= 1'b0;
      ld_result_q   <= 32'd0;
      ld_rd_q       <= 5'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_q          <= rd_d;
      ld_valid_q    <= ld_valid_d;
      ld_result_q   <= ld_result_d;
      ld_rd_q       <= ld_rd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ldValid     = ld_valid_q;
  assign ldResult    = ld_result_q;
  assign ldRd        = ld_rd_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dm_access_controller.sv
// Directed bench for dm_access_controller: inputs change 1 ns after the rising
// edge, outputs are observed on the falling edge.
module tb_dm_access_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_ld, is_st;
  logic [31:0] alu_result, op2;
  logic [4:0]  rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, ld_valid;
  logic [31:0] ld_result;
  logic [4:0]  ld_rd;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_access_controller #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .isLd_DM      (is_ld),
    .isSt_DM      (is_st),
    .aluResult_DM (alu_result),
    .op2_DM       (op2),
    .rd_DM        (rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .ldValid      (ld_valid),
    .ldResult     (ld_result),
    .ldRd         (ld_rd),
    .timeout_err  (timeout_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from its IDLE detection cycle through DONE and returns
  // what was observed. ack arrives in REQ cycle index k (k < 0: never).
  // Returns at the cycle after DONE with the access flags cleared.
  task automatic run_access(input bit ld, input bit st, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] r, input int k,
                            input logic [31:0] rdata, input bit stray_in, input bit stray_out,
                            output int n_stall, output int n_req, output int n_lv,
                            output bit unstable, output bit hung);
    int  req_idx = 0;
    bit  seen_done = 1'b0;
    n_stall = 0; n_req = 0; n_lv = 0; unstable = 1'b0;
    is_ld = ld; is_st = st; alu_result = a; op2 = d; rd = r;
    mem_rdata = rdata; mem_ack = stray_in;
    for (int cyc = 0; cyc < 64 && !seen_done; cyc++) begin
      if (mem_req) begin
        mem_ack = (req_idx == k);
        req_idx++;
      end else if (cyc > 0) begin
        mem_ack = stray_out;
      end
      @(negedge clk);
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        if (mem_addr !== a || mem_wdata !== d || mem_we !== st) unstable = 1'b1;
      end
      if (ld_valid) n_lv++;
      if (cyc > 0 && !stall) seen_done = 1'b1;
      next_cycle();
    end
    is_ld = 1'b0; is_st = 1'b0;
    hung = !seen_done;
  endtask

  task automatic test_reset();
    int ns, nr, nl; bit us, hg;
    rst_n = 1'b0; is_ld = 1'b1; is_st = 1'b0; alu_result = 32'h200; op2 = 32'h0;
    rd = 5'd3; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, ld_valid, ld_result, ld_rd, timeout_err} !== '0 ||
          stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h lv=%b res=%h rd=%0d terr=%b stall=%b, all must be 0",
                 mem_req, mem_we, mem_addr, mem_wdata, ld_valid, ld_result, ld_rd, timeout_err, stall);
      end
    end
    next_cycle();
    rst_n = 1'b1;
    run_access(1'b1, 1'b0, 32'h200, 32'h0, 5'd3, 1, 32'h0BADF00D, 1'b0, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 3 || nr != 2 || nl != 1 || us) begin
      n_fail++;
      $display("FAIL reset_release_access: stall=%0d req=%0d lv=%0d unstable=%b hung=%b, need 3/2/1/0/0",
               ns, nr, nl, us, hg);
    end
    n_checks++;
    if (ld_result !== 32'h0BADF00D || ld_rd !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_release_data: res=%h rd=%0d, need 0badf00d/3", ld_result, ld_rd);
    end
  endtask

  task automatic test_idle_nop();
    is_ld = 1'b0; is_st = 1'b0; mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || ld_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_nop: stall=%b req=%b lv=%b, need 0/0/0", stall, mem_req, ld_valid);
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_load_k0();
    int ns, nr, nl; bit us, hg;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 2 || nr != 1 || nl != 1 || us) begin
      n_fail++;
      $display("FAIL load_k0_timing: stall=%0d req=%0d lv=%0d unstable=%b hung=%b, need 2/1/1/0/0",
               ns, nr, nl, us, hg);
    end
    n_checks++;
    if (ld_result !== 32'hDEADBEEF || ld_rd !== 5'd5 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_k0_data: res=%h rd=%0d terr=%b, need deadbeef/5/0", ld_result, ld_rd, timeout_err);
    end
    @(negedge clk);
    n_checks++;
    if (ld_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_k0_pulse: ldValid=%b one cycle after DONE, need 0", ld_valid);
    end
    next_cycle();
  endtask

  task automatic test_store_k3();
    int ns, nr, nl; bit us, hg;
    run_access(1'b0, 1'b1, 32'h40, 32'h12345678, 5'd9, 3, 32'hFFFFFFFF, 1'b0, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 5 || nr != 4 || nl != 0 || us) begin
      n_fail++;
      $display("FAIL store_k3_timing: stall=%0d req=%0d lv=%0d unstable=%b hung=%b, need 5/4/0/0/0",
               ns, nr, nl, us, hg);
    end
    n_checks++;
    if (ld_result !== 32'hDEADBEEF || ld_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL store_k3_ldresult: res=%h rd=%0d, need deadbeef/5", ld_result, ld_rd);
    end
  endtask

  task automatic test_timeout();
    int ns, nr, nl; bit us, hg;
    run_access(1'b1, 1'b0, 32'h80, 32'h0, 5'd12, -1, 32'h11111111, 1'b0, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 16 || nr != 15 || nl != 0 || us) begin
      n_fail++;
      $display("FAIL timeout_timing: stall=%0d req=%0d lv=%0d unstable=%b hung=%b, need 16/15/0/0/0",
               ns, nr, nl, us, hg);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || ld_result !== 32'hDEADBEEF || ld_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL timeout_flags: terr=%b res=%h rd=%0d, need 1/deadbeef/5", timeout_err, ld_result, ld_rd);
    end
  endtask

  task automatic test_back_to_back();
    int ns, nr, nl; bit us, hg;
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 5'd7, 1, 32'hCAFE0001, 1'b0, 1'b1, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 3 || nr != 2 || nl != 1 || us || ld_result !== 32'hCAFE0001 || ld_rd !== 5'd7) begin
      n_fail++;
      $display("FAIL b2b_load: stall=%0d req=%0d lv=%0d unstable=%b hung=%b res=%h rd=%0d, need 3/2/1/0/0/cafe0001/7",
               ns, nr, nl, us, hg, ld_result, ld_rd);
    end
    run_access(1'b1, 1'b1, 32'h304, 32'h000055AA, 5'd8, 2, 32'h99999999, 1'b1, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 4 || nr != 3 || nl != 0 || us) begin
      n_fail++;
      $display("FAIL b2b_store: stall=%0d req=%0d lv=%0d unstable=%b hung=%b, need 4/3/0/0/0",
               ns, nr, nl, us, hg);
    end
    n_checks++;
    if (ld_result !== 32'hCAFE0001 || ld_rd !== 5'd7 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_state: res=%h rd=%0d terr=%b, need cafe0001/7/1", ld_result, ld_rd, timeout_err);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int ns, nr, nl; bit us, hg;
    bit lv_seen = 1'b0;
    is_ld = 1'b1; is_st = 1'b0; alu_result = 32'h500; rd = 5'd4; mem_ack = 1'b0;
    mem_rdata = 32'h77777777;
    next_cycle();                     // now in REQ cycle 1
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_req1: mem_req=%b, need 1", mem_req);
    end
    next_cycle();                     // REQ cycle 2
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stall: stall=%b while rst_n low, need 0", stall);
    end
    next_cycle();
    n_checks++;
    if (mem_req !== 1'b0 || ld_valid !== 1'b0 || ld_result !== 32'h0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_edge: req=%b lv=%b res=%h terr=%b, need 0/0/0/0",
               mem_req, ld_valid, ld_result, timeout_err);
    end
    rst_n = 1'b1; is_ld = 1'b0; mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_req || ld_valid || stall) lv_seen = 1'b1;
      next_cycle();
    end
    mem_ack = 1'b0;
    n_checks++;
    if (lv_seen) begin
      n_fail++;
      $display("FAIL midrst_no_retry: req/ldValid/stall seen after reset, need none");
    end
    run_access(1'b1, 1'b0, 32'h600, 32'h0, 5'd2, 0, 32'h13572468, 1'b0, 1'b0, ns, nr, nl, us, hg);
    n_checks++;
    if (hg || ns != 2 || nr != 1 || nl != 1 || ld_result !== 32'h13572468 || ld_rd !== 5'd2) begin
      n_fail++;
      $display("FAIL midrst_idle_again: stall=%0d req=%0d lv=%0d hung=%b res=%h rd=%0d, need 2/1/1/0/13572468/2",
               ns, nr, nl, hg, ld_result, ld_rd);
    end
  endtask

  initial begin
    test_reset();
    test_idle_nop();
    test_load_k0();
    test_store_k3();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
